branch_resolve: RTL and testbench

- Execute-side counterpart of the fetch-stage next-PC/1-bit branch predictor.
- Fetch pushes a prediction record (pc, predicted taken, predicted target) for every branch/jump it steers. Execute later supplies the actual outcome.
- The block pops the oldest record, compares prediction against outcome, and drives three registered results:
  - mispredict and redirect to fetch,
  - flush of all younger in-flight records,
  - the history-update strobe back into the predictor table.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bru_pred_fifo.sv | 74 +++++++
 rtl/branch_resolve.sv | 135 +++++++++++++
 tb/tb_branch_resolve.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared widths, opcode constants and prediction record type
//                for the branch predictor / resolver pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int PC_W  = 10;
    localparam int IDX_W = 8;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    localparam logic [6:0] OP_JAL_LIKE = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_rec_t;

endpackage

`default_nettype wire

// File: rtl/bru_pred_fifo.sv
// ============================================================================
//  Module      : bru_pred_fifo
//  Description : In-flight prediction record FIFO with flush; DEPTH must be a
//                power of two (pointers carry one extra wrap bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bru_pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  pred_rec_t                wdata_i,
    output pred_rec_t                rdata_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    pred_rec_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        w_rd_en;
    logic        w_wr_en;

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o     = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO may still accept a write when the head leaves this cycle.
    assign w_rd_en = pop_i && !empty_o;
    assign w_wr_en = push_i && (!full_o || w_rd_en) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
//  Module      : branch_resolve
//  Description : Resolves the oldest fetch prediction against the execute
//                outcome; registers redirect, flush and predictor update.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve
    import bp_pkg::*;
#(
    parameter int PC_W  = bp_pkg::PC_W,
    parameter int IDX_W = bp_pkg::IDX_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     pred_taken,
    input  logic [PC_W-1:0]          pred_target,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_target,
    output logic                     mispredict,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_idx,
    output logic                     upd_taken,
    output logic                     orphan_err,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         cnt_branches,
    output logic [CNT_W-1:0]         cnt_mispred
);

    pred_rec_t        w_head;
    pred_rec_t        w_wrec;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_dir_mis;
    logic             w_tgt_mis;
    logic             w_mis;

    logic             mispredict_q,  mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             upd_valid_q,   upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q,     upd_idx_d;
    logic             upd_taken_q,   upd_taken_d;
    logic             orphan_q,      orphan_d;
    logic [CNT_W-1:0] cnt_br_q,      cnt_br_d;
    logic [CNT_W-1:0] cnt_mp_q,      cnt_mp_d;

    assign w_wrec = '{pc: pred_pc, taken: pred_taken, target: pred_target};

    bru_pred_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pred_valid),
        .pop_i       (res_valid),
        .flush_i     (w_mis),
        .wdata_i     (w_wrec),
        .rdata_o     (w_head),
        .occupancy_o (occupancy),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign w_pop     = res_valid && !w_empty;
    assign w_dir_mis = (w_head.taken != res_taken);
    assign w_tgt_mis = res_taken && (w_head.target != res_target);
    // A mispredict flushes the FIFO, which also swallows any same-cycle push.
    assign w_mis     = w_pop && (w_dir_mis || w_tgt_mis);

    always_comb begin
        mispredict_d  = w_mis;
        upd_valid_d   = w_pop && w_dir_mis;
        redirect_pc_d = redirect_pc_q;
        upd_idx_d     = upd_idx_q;
        upd_taken_d   = upd_taken_q;
        orphan_d      = orphan_q || (res_valid && w_empty);
        cnt_br_d      = cnt_br_q;
        cnt_mp_d      = cnt_mp_q;
        if (w_pop) begin
            redirect_pc_d = res_taken ? res_target : (w_head.pc + PC_STEP);
            upd_idx_d     = w_head.pc[IDX_W-1:0];
            upd_taken_d   = res_taken;
            if (!(&cnt_br_q)) cnt_br_d = cnt_br_q + CNT_W'(1);
        end
        if (w_mis && !(&cnt_mp_q)) cnt_mp_d = cnt_mp_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_idx_q     <= '0;
            upd_taken_q   <= 1'b0;
            orphan_q      <= 1'b0;
            cnt_br_q      <= '0;
            cnt_mp_q      <= '0;
        end else begin
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_idx_q     <= upd_idx_d;
            upd_taken_q   <= upd_taken_d;
            orphan_q      <= orphan_d;
            cnt_br_q      <= cnt_br_d;
            cnt_mp_q      <= cnt_mp_d;
        end
    end

    assign pred_ready   = !w_full;
    assign mispredict   = mispredict_q;
    assign redirect_pc  = redirect_pc_q;
    assign upd_valid    = upd_valid_q;
    assign upd_idx      = upd_idx_q;
    assign upd_taken    = upd_taken_q;
    assign orphan_err   = orphan_q;
    assign cnt_branches = cnt_br_q;
    assign cnt_mispred  = cnt_mp_q;

    // Pushing into a full FIFO is only meaningful alongside a resolution.
    a_push_full: assert property (@(posedge clk) disable iff (rst)
        (pred_valid && !pred_ready) |-> res_valid);

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Scoreboard bench for branch_resolve with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pred_valid = 1'b0;
    logic [9:0] pred_pc = '0;
    logic       pred_taken = 1'b0;
    logic [9:0] pred_target = '0;
    logic       pred_ready;
    logic       res_valid = 1'b0;
    logic       res_taken = 1'b0;
    logic [9:0] res_target = '0;
    logic       mispredict;
    logic [9:0] redirect_pc;
    logic       upd_valid;
    logic [7:0] upd_idx;
    logic       upd_taken;
    logic       orphan_err;
    logic [2:0] occupancy;
    logic [15:0] cnt_branches;
    logic [15:0] cnt_mispred;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk          (clk),
        .rst          (rst),
        .pred_valid   (pred_valid),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_ready   (pred_ready),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_target   (res_target),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .orphan_err   (orphan_err),
        .occupancy    (occupancy),
        .cnt_branches (cnt_branches),
        .cnt_mispred  (cnt_mispred)
    );

    typedef struct {
        logic [9:0] pc;
        logic       tk;
        logic [9:0] tg;
    } mrec_t;

    typedef struct {
        logic       mis;
        logic [9:0] rpc;
        logic       upd;
        logic [7:0] uidx;
        logic       utk;
        logic       orph;
        int         occ;
        logic       rdy;
        int         cb;
        int         cm;
        bit         rstchk;
    } exp_t;

    mrec_t mq[$];
    exp_t  exq[$];
    int    m_cb = 0;
    int    m_cm = 0;
    bit    m_orph = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        n_checks++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exv, $time);
        end
    endtask

    // One clock of stimulus; the model's view of the outputs after the next
    // rising edge is queued for the monitor.
    task automatic step(input bit r, input bit pv, input logic [9:0] ppc, input bit ptk,
                        input logic [9:0] ptg, input bit rv, input bit rtk, input logic [9:0] rtg);
        exp_t       e;
        mrec_t      h;
        logic [9:0] seq;
        bit         dirm;
        bit         tgm;
        @(negedge clk);
        rst = r; pred_valid = pv; pred_pc = ppc; pred_taken = ptk; pred_target = ptg;
        res_valid = rv; res_taken = rtk; res_target = rtg;
        e.mis = 1'b0; e.rpc = '0; e.upd = 1'b0; e.uidx = '0; e.utk = 1'b0; e.rstchk = r;
        if (r) begin
            mq.delete(); m_cb = 0; m_cm = 0; m_orph = 1'b0;
        end else if (rv && mq.size() > 0) begin
            h = mq[0];
            dirm = (h.tk != rtk);
            tgm  = rtk && (h.tg != rtg);
            seq  = h.pc + 10'd4;
            e.rpc = rtk ? rtg : seq;
            e.upd = dirm; e.uidx = h.pc[7:0]; e.utk = rtk;
            if (m_cb < 65535) m_cb++;
            if (dirm || tgm) begin
                e.mis = 1'b1;
                if (m_cm < 65535) m_cm++;
                mq.delete();
            end else begin
                void'(mq.pop_front());
                if (pv) mq.push_back('{pc: ppc, tk: ptk, tg: ptg});
            end
        end else begin
            if (rv) m_orph = 1'b1;
            if (pv && mq.size() < DEPTH) mq.push_back('{pc: ppc, tk: ptk, tg: ptg});
        end
        e.occ = mq.size(); e.rdy = (mq.size() < DEPTH);
        e.orph = m_orph; e.cb = m_cb; e.cm = m_cm;
        exq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic push(input logic [9:0] pc, input bit tk, input logic [9:0] tg);
        step(0, 1, pc, tk, tg, 0, 0, '0);
    endtask

    task automatic resolve(input bit tk, input logic [9:0] tg);
        step(0, 0, '0, 0, '0, 1, tk, tg);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("mispredict", 32'(mispredict), 32'(e.mis));
                chk("upd_valid",  32'(upd_valid),  32'(e.upd));
                if (e.mis) chk("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
                if (e.upd) begin
                    chk("upd_idx",   32'(upd_idx),   32'(e.uidx));
                    chk("upd_taken", 32'(upd_taken), 32'(e.utk));
                end
                if (e.rstchk) begin
                    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
                    chk("rst_upd_idx",     32'(upd_idx),     32'd0);
                    chk("rst_upd_taken",   32'(upd_taken),   32'd0);
                end
                chk("orphan_err",   32'(orphan_err),   32'(e.orph));
                chk("occupancy",    32'(occupancy),    32'(e.occ));
                chk("pred_ready",   32'(pred_ready),   32'(e.rdy));
                chk("cnt_branches", 32'(cnt_branches), 32'(e.cb));
                chk("cnt_mispred",  32'(cnt_mispred),  32'(e.cm));
            end
        end
    end

    initial begin : driver
        mrec_t h;
        bit    pv;
        bit    rv;
        bit    rtk;
        logic [9:0] rtg;
        logic [9:0] ppc;
        int    kind;

        repeat (3) step(1, 0, '0, 0, '0, 0, 0, '0);

        // correct not-taken
        push(10'h040, 0, 10'h044); resolve(0, 10'h000); idle();
        // direction mispredict
        push(10'h040, 0, 10'h044); resolve(1, 10'h080); idle();
        // target-only mispredict flushes younger records
        push(10'h100, 1, 10'h120); push(10'h124, 0, 10'h128); push(10'h128, 0, 10'h12C);
        resolve(1, 10'h140); idle(); idle();
        // not-taken redirect wraps past the top of the PC space
        push(10'h3FC, 1, 10'h010); resolve(0, 10'h000); idle();
        // fill, then push and pop together while full; order must survive
        for (int i = 0; i < 4; i++) push(10'h200 + 10'(4 * i), 1'(i % 2), 10'h300 + 10'(4 * i));
        step(0, 1, 10'h210, 0, 10'h214, 1, 0, 10'h000);
        resolve(1, 10'h304); resolve(0, 10'h000); resolve(1, 10'h30C); resolve(0, 10'h000);
        idle();
        // orphan resolution, then reset with entries queued
        resolve(1, 10'h055); idle();
        push(10'h020, 0, 10'h024); push(10'h030, 0, 10'h034);
        step(1, 0, '0, 0, '0, 0, 0, '0); idle();

        for (int n = 0; n < 1500; n++) begin
            pv  = ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 2) == 0);
            ppc = 10'($urandom);
            rtk = 1'($urandom);
            rtg = 10'($urandom);
            if (rv && mq.size() > 0) begin
                h    = mq[0];
                kind = int'($urandom_range(0, 5));
                if (kind == 0) begin
                    rtk = !h.tk; rtg = h.tg;
                end else if (kind == 1) begin
                    rtk = 1'b1; rtg = h.tg ^ 10'h004;
                end else begin
                    rtk = h.tk; rtg = h.tk ? h.tg : rtg;
                end
            end
            if (mq.size() >= DEPTH && !rv) pv = 1'b0;
            step($urandom_range(0, 199) == 0, pv, ppc, 1'($urandom), ppc + 10'd4, rv, rtk, rtg);
        end
        idle();

        for (int i = 0; i < 10 && exq.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses never checked, required 0", exq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
